// File: rtl/lane_unpacker.sv
// lane_unpacker: splits a packed NUM_LANES x LANE_W word into one lane per cycle,
// checks the lane-0 header and keeps a saturating count of bad-header words.
// Optional feature: define LANE_UNPACKER_SKIP_ZERO_EN to suppress all-zero lanes
// above lane 0. The default build emits every lane.
module lane_unpacker #(
  parameter int unsigned LANE_W    = 12,
  parameter int unsigned NUM_LANES = 3,
  parameter int unsigned IDX_W     = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_LANES*LANE_W-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANE_W-1:0]           out_lane,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        out_last,
  output logic                        out_hdr_err,
  output logic [7:0]                  err_cnt
);

  localparam int unsigned DATA_W = NUM_LANES * LANE_W;
  localparam int unsigned CNT_W  = IDX_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     word_q, word_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  last_q, last_d;
  logic                  hdr_err_q, hdr_err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic [NUM_LANES-1:0]  cap_mask;
  logic [NUM_LANES-1:0]  word_mask;
  logic                  cap_last;
  logic [IDX_W-1:0]      adv_idx;
  logic                  adv_last;
  logic [LANE_W-1:0]     adv_lane;
  logic                  hdr_bad;
  logic                  out_accept;
  logic                  word_done;
  logic                  capture;

  // First emitted lane above 'from' according to the emit mask; NUM_LANES if none.
  function automatic logic [CNT_W-1:0] next_idx(input logic [NUM_LANES-1:0] mask,
                                                 input logic [IDX_W-1:0]     from);
    next_idx = CNT_W'(NUM_LANES);
    for (int k = int'(NUM_LANES) - 1; k >= 1; k--) begin
      if (k > int'(from) && mask[k]) next_idx = CNT_W'(k);
    end
  endfunction

  // Which lanes of the incoming and captured words get emitted.
  always_comb begin
    cap_mask  = '1;
    word_mask = '1;
`ifdef LANE_UNPACKER_SKIP_ZERO_EN
    for (int k = 1; k < int'(NUM_LANES); k++) begin
      cap_mask[k]  = |in_data[k*LANE_W +: LANE_W];
      word_mask[k] = |word_q[k*LANE_W +: LANE_W];
    end
`endif
  end

  // Lane sequencing, header check and handshake decode.
  always_comb begin
    cap_last   = (next_idx(cap_mask, '0) == CNT_W'(NUM_LANES));
    adv_idx    = IDX_W'(next_idx(word_mask, idx_q));
    adv_last   = (next_idx(word_mask, adv_idx) == CNT_W'(NUM_LANES));
    adv_lane   = word_q[int'(adv_idx)*LANE_W +: LANE_W];
    hdr_bad    = !((in_data[LANE_W-1 -: 2] == 2'b00) && in_data[LANE_W-3]);
    out_accept = (state_q == SEND) && out_ready;
    word_done  = out_accept && last_q;
    in_ready   = (state_q == IDLE) || word_done;
    capture    = in_valid && in_ready;
  end

  // Next-state for the FSM, output registers and error counter.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    lane_d    = lane_q;
    idx_d     = idx_q;
    last_d    = last_q;
    hdr_err_d = hdr_err_q;
    err_cnt_d = err_cnt_q;

    if (capture) begin
      state_d   = SEND;
      word_d    = in_data;
      lane_d    = in_data[LANE_W-1:0];
      idx_d     = '0;
      last_d    = cap_last;
      hdr_err_d = hdr_bad;
    end else if (word_done) begin
      state_d   = IDLE;
    end else if (out_accept) begin
      lane_d    = adv_lane;
      idx_d     = adv_idx;
      last_d    = adv_last;
      hdr_err_d = 1'b0;
    end

    if (out_accept && (idx_q == '0) && hdr_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State and output registers; reset discards any in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      word_q    <= '0;
      lane_q    <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      hdr_err_q <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      lane_q    <= lane_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      hdr_err_q <= hdr_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid   = (state_q == SEND);
  assign out_lane    = lane_q;
  assign out_idx     = idx_q;
  assign out_last    = last_q;
  assign out_hdr_err = hdr_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_lane_unpacker.sv
// Scoreboard bench for lane_unpacker: directed vectors plus randomized words and
// backpressure, checked against a lane-list reference model.
module tb_lane_unpacker;

  localparam int unsigned LANE_W    = 12;
  localparam int unsigned NUM_LANES = 3;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned DATA_W    = NUM_LANES * LANE_W;

  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic [IDX_W-1:0]  idx;
    logic              last;
    logic              err;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [LANE_W-1:0] out_lane;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;
  logic              out_hdr_err;
  logic [7:0]        err_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  beat_t       exp_q[$];
  int unsigned err_model = 0;
  int          ready_mode = 0;
  int          run_len = 0;
  int          max_run = 0;
  int          pushed = 0;
  logic        prev_stall = 1'b0;
  beat_t       held = '0;

  lane_unpacker #(.LANE_W(LANE_W), .NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane(out_lane),
    .out_idx(out_idx), .out_last(out_last), .out_hdr_err(out_hdr_err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: list of lanes a word produces, built from the lane rules.
  function automatic void model_word(input logic [DATA_W-1:0] w);
    beat_t bq[$];
    beat_t b;
    logic [LANE_W-1:0] l;
    l = w[LANE_W-1:0];
    b.lane = l;
    b.idx  = '0;
    b.last = 1'b0;
    b.err  = !(l[11:10] == 2'b00 && l[9] == 1'b1);
    bq.push_back(b);
    for (int k = 1; k < int'(NUM_LANES); k++) begin
      l = w[k*LANE_W +: LANE_W];
`ifdef LANE_UNPACKER_SKIP_ZERO_EN
      if (l == '0) continue;
`endif
      b.lane = l;
      b.idx  = IDX_W'(k);
      b.last = 1'b0;
      b.err  = 1'b0;
      bq.push_back(b);
    end
    b = bq.pop_back();
    b.last = 1'b1;
    bq.push_back(b);
    foreach (bq[i]) exp_q.push_back(bq[i]);
    pushed += bq.size();
  endfunction

  // Present one word (called at posedge+2) and hold it until accepted.
  task automatic send_word(input logic [DATA_W-1:0] w, input int gap);
    logic acc;
    in_valid = 1'b1;
    in_data  = w;
    model_word(w);
    acc = 1'b0;
    for (int c = 0; c < 2000 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #2;
    end
    if (!acc) check("accept_timeout", 64'(0), 64'(1));
    if (gap > 0) begin
      in_valid = 1'b0;
      in_data  = DATA_W'({$urandom(), $urandom()});
      repeat (gap) begin
        @(posedge clk);
        #2;
      end
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 5000 && exp_q.size() != 0; c++) begin
      @(posedge clk);
      #2;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #2;
  endtask

  // Wait (at posedge+2) for the idx1 beat to be presented.
  task automatic wait_idx1();
    logic found;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (out_valid && out_idx == IDX_W'(1)) found = 1'b1;
      else begin
        @(posedge clk);
        #2;
      end
    end
    check("idx1_seen", 64'(found), 64'(1));
  endtask

  // Consumer backpressure: 0 always ready, 1 random, 2 manual.
  always @(posedge clk) begin
    #2;
    if (ready_mode == 0) out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops expected beats on each output handshake and checks side signals.
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    cur = {out_lane, out_idx, out_last, out_hdr_err};
    if (!rst_n) begin
      prev_stall = 1'b0;
      err_model  = 0;
      run_len    = 0;
    end else begin
      check("in_ready", 64'(in_ready), 64'(!out_valid || (out_ready && out_last)));
      check("err_cnt", 64'(err_cnt), 64'(err_model));
      if (out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else run_len = 0;
      if (out_valid && prev_stall) check("hold_stable", 64'(cur), 64'(held));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 64'(cur), 64'(0));
        else begin
          e = exp_q.pop_front();
          check("beat{lane,idx,last,err}", 64'(cur), 64'(e));
          if (e.err && e.idx == '0 && err_model < 255) err_model++;
        end
      end
      prev_stall = out_valid && !out_ready;
      held = cur;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    logic [DATA_W-1:0] w;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_lane", 64'(out_lane), 64'(0));
    check("rst_out_idx", 64'(out_idx), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_hdr_err", 64'(out_hdr_err), 64'(0));
    check("rst_err_cnt", 64'(err_cnt), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Basic word
    send_word(36'hABC_123_200, 0);
    in_valid = 1'b0;
    wait_drain();

    // Back-to-back words, no bubble
    max_run = 0;
    b0 = pushed;
    send_word(36'h456_789_2AB, 0);
    send_word(36'h111_222_3CD, 0);
    in_valid = 1'b0;
    wait_drain();
    check("no_bubble_run", 64'(max_run), 64'(pushed - b0));

    // Bad header
    send_word(36'h001_002_E00, 0);
    in_valid = 1'b0;
    wait_drain();
    check("err_cnt_one", 64'(err_cnt), 64'(8'd1));

    // Stall at idx1 for 5 cycles
    ready_mode = 2;
    out_ready  = 1'b1;
    send_word(36'hABC_123_200, 0);
    in_valid = 1'b0;
    wait_idx1();
    out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #2;
      check("stall_lane", 64'(out_lane), 64'(12'h123));
      check("stall_idx", 64'(out_idx), 64'(1));
      check("stall_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    wait_drain();

    // Async reset mid-word
    send_word(36'h0AA_055_300, 0);
    in_valid = 1'b0;
    wait_idx1();
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'(0));
    check("async_rst_idx", 64'(out_idx), 64'(0));
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    check("post_rst_err_cnt", 64'(err_cnt), 64'(0));
    @(posedge clk);
    #2;
    ready_mode = 0;
    send_word(36'h123_456_200, 0);
    in_valid = 1'b0;
    wait_drain();

    // Zero-lane words
    send_word(36'hABC_000_200, 1);
    send_word(36'h000_000_200, 0);
    in_valid = 1'b0;
    wait_drain();

    // Randomized words with random backpressure and gaps
    ready_mode = 1;
    for (int n = 0; n < 200; n++) begin
      w = DATA_W'({$urandom(), $urandom()});
      for (int k = 1; k < int'(NUM_LANES); k++) begin
        if ($urandom_range(0, 3) == 0) w[k*LANE_W +: LANE_W] = '0;
      end
      if ($urandom_range(0, 1) == 1) w[11:9] = 3'b001;
      send_word(w, int'($urandom_range(0, 2)));
    end
    in_valid = 1'b0;
    wait_drain();

    // Saturation of the error counter
    ready_mode = 0;
    for (int n = 0; n < 300; n++) send_word(36'h001_002_E00, 0);
    in_valid = 1'b0;
    wait_drain();
    check("err_cnt_saturated", 64'(err_cnt), 64'(8'hFF));
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lane_unpacker.md
Name: lane_unpacker

Overview:
- Receive end of the 12-bit lane packing used by the hierarchical netlist flow: accepts one packed multi-lane word and emits it one lane per cycle.
- The packing side builds words of NUM_LANES x 12-bit lanes, lane 0 carrying a header field. This block splits the word back into lanes, checks the lane-0 header and counts header errors.
- Sits between a packed-word source and a narrow 12-bit lane consumer. Valid/ready handshake on both sides.

Parameters:
- LANE_W, 12, width of one lane in bits.
- NUM_LANES, 3, lanes per packed word; legal range 2..4.
- IDX_W, 2, width of out_idx; must satisfy 2^IDX_W >= NUM_LANES.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  packed word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  NUM_LANES*LANE_W  packed word; lane k = in_data[k*LANE_W +: LANE_W].
- out_valid  output  1  out_lane valid.
- out_ready  input  1  consumer accepts lane.
- out_lane  output  LANE_W  current lane data.
- out_idx  output  IDX_W  index of current lane.
- out_last  output  1  current lane is the final lane of the word.
- out_hdr_err  output  1  lane-0 header bad; valid only with out_idx==0.
- err_cnt  output  8  saturating count of words with a bad header.

Behaviour:
- Reset (async, rst_n low) values:
  - out_valid=0, out_lane=0, out_idx=0, out_last=0, out_hdr_err=0, err_cnt=0.
  - in_ready=1. Internal word register cleared. FSM to IDLE.
  - An in-flight word is discarded without completion. Deassertion is synchronous to clk.
- FSM has two states, IDLE and SEND.
  - IDLE: in_ready=1, out_valid=0. If in_valid is high at a clock edge:
    - capture in_data;
    - load lane 0 into out_lane, out_idx=0;
    - compute out_hdr_err;
    - go to SEND.
  - SEND: out_valid=1. On out_valid&&out_ready the next lane is loaded and out_idx increments.
  - Accept with out_last=1 ends the word:
    - if in_valid is also high the same edge, capture the new word and stay in SEND with lane 0 (back-to-back, no bubble);
    - otherwise go to IDLE.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is combinational from out_ready.
- Latency is one cycle from word acceptance to lane 0 on the output. A word without stalls occupies NUM_LANES cycles.
- Output stability: while out_valid && !out_ready, out_lane, out_idx, out_last and out_hdr_err hold unchanged.
- out_last = (out_idx == NUM_LANES-1).
- Header rule for lane 0:
  - valid when lane0[11:10]==2'b00 and lane0[9]==1;
  - otherwise out_hdr_err=1 for the lane-0 beat, and 0 on all other beats.
  - The data is still forwarded unchanged.
- err_cnt increments by 1 on the cycle lane 0 with out_hdr_err=1 is accepted (out_ready high). It saturates at 8'hFF and is cleared only by reset.
- in_valid while the block is busy and not on a last-lane accept: the word is not captured. The source must hold it.

Optional Feature:
- Macro: LANE_UNPACKER_SKIP_ZERO_EN.
- Defined:
  - lanes 1..NUM_LANES-1 equal to all-zero are not emitted; the next non-zero lane follows directly;
  - out_idx still reports the true lane index, so gaps are visible;
  - out_last asserts on the last non-zero lane. If all lanes above 0 are zero, lane 0 carries out_last=1;
  - lane 0 is always emitted;
  - the skip decision uses the captured word, so there is no extra latency.
- Not defined: every lane is emitted, exactly as described in Behaviour.

Test Plan:
- Reset, then in_data=36'hABC_123_200 with out_ready=1.
  -> Lanes are 0x200/idx0/err0, 0x123/idx1, 0xABC/idx2/last; err_cnt=0; in_ready high the cycle after last.
- Two words back-to-back, in_valid held high, out_ready=1.
  -> 6 consecutive out_valid cycles with no bubble; second lane 0 appears the cycle after the first word's last.
- Word 36'h001_002_E00 (bad header).
  -> out_hdr_err=1 on idx0 only; data forwarded; err_cnt=1. Repeat 300 words -> err_cnt=8'hFF.
- out_ready low for 5 cycles at idx1.
  -> out_lane=0x123, idx1 held stable; in_ready=0; no lane lost.
- rst_n pulsed low mid-word at idx1.
  -> out_valid drops immediately (async); after release in_ready=1, err_cnt=0, the next word starts at idx0.
- With LANE_UNPACKER_SKIP_ZERO_EN, word 36'hABC_000_200.
  -> 0x200/idx0, then 0xABC/idx2/last. Word 36'h000_000_200 -> single beat idx0 with last=1.
